// File: rtl/timer_pkg.sv
// Shared constants and types for the multi-channel timer.
package timer_pkg;

    // Register offsets within one channel's 4-word window.
    localparam logic [1:0] REG_LOAD   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Bit positions inside CTRL.
    localparam int CTRL_EN    = 0;
    localparam int CTRL_PER   = 1;
    localparam int CTRL_IRQEN = 2;

    // Channel run state; the CTRL en bit reads back as (state == CH_RUN).
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: LOAD/CTRL/COUNT/flag storage and the
// IDLE/RUN state machine. Advances only on the shared prescaler tick.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load_wr,
    input  logic             ctrl_wr,
    input  logic             status_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] count,
    output logic             periodic,
    output logic             irq_en,
    output logic             flag,
    output logic             done,
    output ch_state_t        state
);

    ch_state_t        state_next;
    logic [WIDTH-1:0] count_next;
    logic             expire;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CH_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next state: a CTRL write with en=0 beats a same-cycle tick; a start
    // copies LOAD into COUNT; expiry at COUNT==0 reloads or stops.
    always_comb begin
        state_next = state;
        count_next = count;
        expire     = 1'b0;
        case (state)
            CH_IDLE: begin
                if (ctrl_wr && wr_data[CTRL_EN]) begin
                    state_next = CH_RUN;
                    count_next = load;
                end
            end
            CH_RUN: begin
                if (ctrl_wr && !wr_data[CTRL_EN]) begin
                    state_next = CH_IDLE;
                end else if (tick) begin
                    if (count == '0) begin
                        expire = 1'b1;
                        if (periodic) begin
                            count_next = load;
                        end else begin
                            state_next = CH_IDLE;
                        end
                    end else begin
                        count_next = count - 1'b1;
                    end
                end
            end
            default: state_next = CH_IDLE;
        endcase
    end

    // Software-visible config, sticky flag (set beats clear) and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load     <= '0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            flag     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load_wr) begin
                load <= wr_data;
            end
            if (ctrl_wr) begin
                periodic <= wr_data[CTRL_PER];
                irq_en   <= wr_data[CTRL_IRQEN];
            end
            if (expire) begin
                flag <= 1'b1;
            end else if (status_wr && wr_data[0]) begin
                flag <= 1'b0;
            end
            done <= expire;
        end
    end

endmodule

// File: rtl/timer_multi.sv
// NUM_CH independent down-counting timers sharing one programmable
// prescaler, with a {channel, reg} register port and an OR-ed interrupt.
module timer_multi
    import timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [PRESC_W-1:0]        presc_div,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)+1:0] wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [$clog2(NUM_CH)+1:0] rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic [NUM_CH-1:0]         done,
    output logic                      irq
);

    localparam int AW = $clog2(NUM_CH) + 2;

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    logic [WIDTH-1:0]  ch_load  [NUM_CH];
    logic [WIDTH-1:0]  ch_count [NUM_CH];
    ch_state_t         ch_state [NUM_CH];
    logic [NUM_CH-1:0] ch_per;
    logic [NUM_CH-1:0] ch_irq_en;
    logic [NUM_CH-1:0] ch_flag;
    logic [WIDTH-1:0]  rd_next;

    assign tick = ena && (presc_cnt == presc_div);

    // Prescaler: counts 0..presc_div, wraps after the tick; a count left
    // above a newly lowered divider wraps to 0 without a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (ena) begin
            if (presc_cnt >= presc_div) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_en && ((wr_addr >> 2) == AW'(i));

        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .load_wr   (sel && (wr_addr[1:0] == REG_LOAD)),
            .ctrl_wr   (sel && (wr_addr[1:0] == REG_CTRL)),
            .status_wr (sel && (wr_addr[1:0] == REG_STATUS)),
            .wr_data   (wr_data),
            .load      (ch_load[i]),
            .count     (ch_count[i]),
            .periodic  (ch_per[i]),
            .irq_en    (ch_irq_en[i]),
            .flag      (ch_flag[i]),
            .done      (done[i]),
            .state     (ch_state[i])
        );
    end

    // Read mux; addresses of channels that do not exist read as 0.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((rd_addr >> 2) == AW'(i)) begin
                case (rd_addr[1:0])
                    REG_LOAD:  rd_next = ch_load[i];
                    REG_CTRL: begin
                        rd_next[CTRL_EN]    = (ch_state[i] == CH_RUN);
                        rd_next[CTRL_PER]   = ch_per[i];
                        rd_next[CTRL_IRQEN] = ch_irq_en[i];
                    end
                    REG_COUNT: rd_next = ch_count[i];
                    default:   rd_next[0] = ch_flag[i];
                endcase
            end
        end
    end

    // Registered read data: one cycle latency, old value on write collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

    assign irq = |(ch_flag & ch_irq_en);

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed scenarios plus random
// register traffic, all compared cycle by cycle with a behavioural model.
module tb_timer_multi;

    localparam int NUM_CH  = 4;
    localparam int WIDTH   = 16;
    localparam int PRESC_W = 8;
    localparam int AW      = $clog2(NUM_CH) + 2;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic [PRESC_W-1:0] presc_div;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic [AW-1:0]      rd_addr;
    logic [WIDTH-1:0]   rd_data;
    logic [NUM_CH-1:0]  done;
    logic               irq;

    always #5 clk = ~clk;

    timer_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .presc_div (presc_div),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .done      (done),
        .irq       (irq)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int                checks = 0;
    int                errors = 0;
    int                cyc    = 0;
    int                m_pc;
    int                m_load  [NUM_CH];
    int                m_count [NUM_CH];
    bit                m_run   [NUM_CH];
    bit                m_per   [NUM_CH];
    bit                m_irqen [NUM_CH];
    bit                m_flag  [NUM_CH];
    logic [NUM_CH-1:0] m_done;
    logic [WIDTH-1:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_pc   = 0;
        m_done = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_load[c]  = 0;
            m_count[c] = 0;
            m_run[c]   = 0;
            m_per[c]   = 0;
            m_irqen[c] = 0;
            m_flag[c]  = 0;
        end
    endfunction

    function automatic logic [WIDTH-1:0] model_read(input int addr);
        int ch = addr / 4;
        int r  = addr % 4;
        if (ch >= NUM_CH) return '0;
        case (r)
            0:       return WIDTH'(m_load[ch]);
            1:       return WIDTH'(int'(m_run[ch]) + 2 * int'(m_per[ch]) + 4 * int'(m_irqen[ch]));
            2:       return WIDTH'(m_count[ch]);
            default: return WIDTH'(m_flag[ch]);
        endcase
    endfunction

    function automatic logic model_irq();
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_flag[c] && m_irqen[c]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock edge of the timer as the register-level rules describe it.
    function automatic void model_step();
        bit tick;
        int wch, wreg;
        exp_q.push_back(model_read(int'(rd_addr)));
        tick = ena && (m_pc == int'(presc_div));
        if (ena) m_pc = (m_pc >= int'(presc_div)) ? 0 : m_pc + 1;
        wch    = int'(wr_addr) / 4;
        wreg   = int'(wr_addr) % 4;
        m_done = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bit cw = wr_en && wch == c && wreg == 1;
            bit lw = wr_en && wch == c && wreg == 0;
            bit sw = wr_en && wch == c && wreg == 3;
            if (m_run[c]) begin
                if (cw && !wr_data[0]) begin
                    m_run[c] = 0;
                end else if (tick) begin
                    if (m_count[c] == 0) begin
                        m_done[c] = 1'b1;
                        if (m_per[c]) m_count[c] = m_load[c];
                        else          m_run[c]   = 0;
                    end else begin
                        m_count[c] = m_count[c] - 1;
                    end
                end
            end else if (cw && wr_data[0]) begin
                m_run[c]   = 1;
                m_count[c] = m_load[c];
            end
            if (cw) begin
                m_per[c]   = wr_data[1];
                m_irqen[c] = wr_data[2];
            end
            if (lw) m_load[c] = int'(wr_data);
            if (m_done[c]) m_flag[c] = 1;
            else if (sw && wr_data[0]) m_flag[c] = 0;
        end
    endfunction

    // ---------------- scoreboard / driver tasks ----------------
    task automatic compare_all();
        if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
        check("done", done, m_done);
        check("irq", irq, model_irq());
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            model_step();
        end
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic write_reg(input int ch, input int r, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(ch * 4 + r);
        wr_data = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input int ch, input int max, input string tag, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            cycle();
            if (done[ch]) begin
                at = cyc;
                return;
            end
        end
        check(tag, 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        exp_q.delete();
        check("rst_rd_data", rd_data, 0);
        check("rst_done", done, 0);
        check("rst_irq", irq, 0);
        cycle();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, t2, t3, t4, n;
        bit hit;
        rst = 1'b1; ena = 1'b1; presc_div = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;

        // One-shot, prescaler off: expiry 6 ticks after start.
        write_reg(0, 0, 16'd5);
        write_reg(0, 1, 16'b101);
        t0 = cyc;
        wait_done(0, 50, "timeout_oneshot", t1);
        check("oneshot_latency", t1 - t0, 6);
        rd_addr = AW'(3); cycle();
        check("oneshot_flag", rd_data, 1);
        check("oneshot_irq", irq, 1);
        rd_addr = AW'(1); cycle();
        check("oneshot_ctrl", rd_data, 16'b100);
        rd_addr = AW'(2); cycle();
        check("oneshot_count", rd_data, 0);
        n = 0;
        repeat (10) begin cycle(); if (done[0]) n++; end
        check("oneshot_no_repeat", n, 0);
        write_reg(0, 3, 16'd1);

        // Periodic with presc_div=3: 12 clk period, LOAD change lands late.
        presc_div = 8'd3;
        write_reg(1, 0, 16'd2);
        write_reg(1, 1, 16'b011);
        wait_done(1, 100, "timeout_per_a", t1);
        wait_done(1, 100, "timeout_per_b", t2);
        check("periodic_12", t2 - t1, 12);
        write_reg(1, 0, 16'd4);
        wait_done(1, 100, "timeout_per_c", t3);
        check("periodic_old_load", t3 - t2, 12);
        wait_done(1, 100, "timeout_per_d", t4);
        check("periodic_new_load", t4 - t3, 20);
        write_reg(1, 1, 16'd0);
        write_reg(1, 3, 16'd1);

        // Channel independence.
        presc_div = 8'd0;
        write_reg(0, 0, 16'd1);
        write_reg(3, 0, 16'd3);
        write_reg(0, 1, 16'b011);
        write_reg(3, 1, 16'b011);
        wait_done(0, 20, "timeout_ind0_a", t1);
        wait_done(0, 20, "timeout_ind0_b", t2);
        check("ch0_period_2", t2 - t1, 2);
        wait_done(3, 20, "timeout_ind3_a", t1);
        wait_done(3, 20, "timeout_ind3_b", t2);
        check("ch3_period_4", t2 - t1, 4);
        write_reg(0, 1, 16'd0);
        write_reg(3, 1, 16'd0);
        write_reg(0, 3, 16'd1);
        write_reg(3, 3, 16'd1);

        // W1C on the expiry edge: set wins; a later lone w1c clears irq.
        write_reg(2, 0, 16'd3);
        write_reg(2, 1, 16'b111);
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_run[2] && m_count[2] == 0) begin
                write_reg(2, 3, 16'd1);
                hit = 1;
                break;
            end
            cycle();
        end
        check("w1c_race_reached", hit, 1);
        check("w1c_race_done", done[2], 1);
        check("w1c_race_irq", irq, 1);
        write_reg(2, 1, 16'b100);
        write_reg(2, 3, 16'd1);
        check("w1c_clear_irq", irq, 0);

        // ena gating freezes COUNT, then a CTRL en=0 stop holds it.
        write_reg(2, 0, 16'd100);
        write_reg(2, 1, 16'b011);
        rd_addr = AW'(2 * 4 + 2);
        repeat (5) cycle();
        ena = 1'b0;
        repeat (10) cycle();
        check("ena_frozen", rd_data, 95);
        ena = 1'b1;
        repeat (5) cycle();
        check("ena_resume", rd_data, 91);
        write_reg(2, 1, 16'b010);
        n = 0;
        repeat (10) begin cycle(); if (done[2]) n++; end
        check("stop_no_done", n, 0);
        check("stop_hold", rd_data, 90);

        // Random register traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) presc_div = PRESC_W'($urandom_range(0, 3));
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom);
            wr_data = (wr_addr[1:0] == 2'd0) ? WIDTH'($urandom_range(0, 6))
                                             : WIDTH'($urandom_range(0, 7));
            rd_addr = AW'($urandom);
            if ($urandom_range(0, 999) == 0) pulse_reset();
            cycle();
        end
        wr_en = 1'b0;

        // Reset mid-run: everything reads back as zero.
        write_reg(1, 0, 16'd7);
        write_reg(1, 1, 16'b111);
        repeat (3) cycle();
        pulse_reset();
        for (int a = 0; a < NUM_CH * 4; a++) begin
            rd_addr = AW'(a);
            cycle();
            check("rst_read", rd_data, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
